// File: rtl/score_display_sequencer_if.sv
// Requester / display bus for score_display_sequencer: point-add handshakes,
// frame timing and the published score digits.
interface score_display_sequencer_if #(
    parameter int PTS_W = 8
);
    logic             req0;
    logic [PTS_W-1:0] pts0;
    logic             req1;
    logic [PTS_W-1:0] pts1;
    logic             ack0;
    logic             ack1;
    logic             clr_score;
    logic             frame_start;
    logic [20:0]      score;
    logic [23:0]      digits;
    logic             digits_valid;
    logic             busy;
    logic             saturated;

    modport master (
        output req0, pts0, req1, pts1, clr_score, frame_start,
        input  ack0, ack1, score, digits, digits_valid, busy, saturated
    );

    modport slave (
        input  req0, pts0, req1, pts1, clr_score, frame_start,
        output ack0, ack1, score, digits, digits_valid, busy, saturated
    );
endinterface

// File: rtl/score_display_sequencer.sv
// Score register with round-robin add arbitration, bit-serial binary-to-BCD
// conversion and frame-synchronous digit publish. Option: LEADING_ZERO_BLANK_EN.
module score_display_sequencer #(
    parameter int unsigned MAX_SCORE = 999999,
    parameter int          PTS_W     = 8
) (
    input logic                     clk,
    input logic                     rst,
    score_display_sequencer_if.slave bus
);
    localparam logic [21:0] MAX22 = 22'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, CONV, WAIT} state_t;

    state_t      state_q, state_d;
    logic [20:0] score_q, score_d;
    logic        sat_q, sat_d;
    logic        rr_q, rr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        dirty_q, dirty_d;
    logic [20:0] sh_q, sh_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] digits_q, digits_d;
    logic        valid_q, valid_d;

    logic        load_snap, conv_step, publish, busy;
    logic        elig0, elig1, grant0, grant1;
    logic [PTS_W-1:0] pts_sel;
    logic [21:0] sum;
    logic [23:0] adj;
    logic [23:0] pub_val;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dirty_q) state_d = CONV;
            CONV:    if (cnt_q == 5'd20) state_d = WAIT;
            WAIT:    if (bus.frame_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_snap = (state_q == IDLE) && dirty_q;
        conv_step = (state_q == CONV);
        publish   = (state_q == WAIT) && bus.frame_start;
        busy      = (state_q == CONV);
    end

    // A requester being acked this cycle is skipped so it can drop req next edge.
    always_comb begin
        elig0   = bus.req0 && !ack0_q;
        elig1   = bus.req1 && !ack1_q;
        grant1  = !bus.clr_score && elig1 && (!elig0 || !rr_q);
        grant0  = !bus.clr_score && elig0 && !grant1;
        pts_sel = grant1 ? bus.pts1 : bus.pts0;
        sum     = {1'b0, score_q} + 22'(pts_sel);
    end

    always_comb begin
        score_d = score_q;
        sat_d   = sat_q;
        rr_d    = rr_q;
        ack0_d  = grant0;
        ack1_d  = grant1;
        dirty_d = dirty_q;
        if (load_snap) dirty_d = 1'b0;
        if (bus.clr_score) begin
            score_d = '0;
            sat_d   = 1'b0;
            dirty_d = 1'b1;
        end else if (grant0 || grant1) begin
            if (sum > MAX22) begin
                score_d = MAX22[20:0];
                sat_d   = 1'b1;
            end else begin
                score_d = sum[20:0];
            end
            rr_d    = grant1;
            dirty_d = 1'b1;
        end
    end

    // Double-dabble step: add-3 on nibbles >= 5, then shift {bcd, sh} left.
    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (load_snap) begin
            sh_d  = score_q;
            bcd_d = '0;
            cnt_d = '0;
        end else if (conv_step) begin
            sh_d  = {sh_q[19:0], 1'b0};
            bcd_d = {adj[22:0], sh_q[20]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_comb begin
        pub_val = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int unsigned k = 0; k < 5; k++) begin
                if (lead && (bcd_q[4*(5-k) +: 4] == 4'd0)) pub_val[4*(5-k) +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        digits_d = digits_q;
        valid_d  = valid_q;
        if (publish) begin
            digits_d = pub_val;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q  <= '0;
            sat_q    <= 1'b0;
            rr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            dirty_q  <= 1'b1;
            sh_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            score_q  <= score_d;
            sat_q    <= sat_d;
            rr_q     <= rr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            dirty_q  <= dirty_d;
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.score        = score_q;
    assign bus.digits       = digits_q;
    assign bus.digits_valid = valid_q;
    assign bus.busy         = busy;
    assign bus.saturated    = sat_q;
endmodule

// File: doc/score_display_sequencer.md
Name: score_display_sequencer

Overview:
- Owns the game score register and arbitrates point-add requests from two game-logic requesters using round-robin.
- Converts the binary score to six BCD digits with a sequential double-dabble engine, one bit per cycle.
- Publishes the digits to the VGA scoreboard renderer only on frame boundaries, so digits never tear mid-frame.
- Replaces per-pixel division in the renderer with a registered, frame-synchronous digit bus.

Parameters:
- MAX_SCORE, 999999: saturation ceiling for the score; must fit in 21 bits.
- PTS_W, 8: width of each requester's points field.

Ports:
- clk  input  1  system pixel clock
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 add request; held with pts0 stable until ack0
- pts0  input  PTS_W  points to add for requester 0
- req1  input  1  requester 1 add request; held with pts1 stable until ack1
- pts1  input  PTS_W  points to add for requester 1
- ack0  output  1  one-cycle pulse: requester 0 add applied
- ack1  output  1  one-cycle pulse: requester 1 add applied
- clr_score  input  1  zero the score (game restart)
- frame_start  input  1  one-cycle pulse at the start of vertical blank
- score  output  21  current binary score
- digits  output  24  published BCD digits; [23:20] = hundred-thousands … [3:0] = units
- digits_valid  output  1  high once the first conversion has been published
- busy  output  1  high while the FSM is in CONV
- saturated  output  1  sticky; set when any add clipped at MAX_SCORE, cleared by clr_score or rst

Behaviour:
Reset (synchronous, active-high):
- score=0, digits=24'h000000, digits_valid=0, ack0=ack1=0, busy=0, saturated=0.
- RR pointer=0, meaning requester 1 has priority on the next conflict.
- dirty=1, FSM=IDLE.
- rst asserted mid-conversion abandons the conversion; no publish occurs.

Arbitration (one grant per cycle):
- Eligible_i = req_i && !ack_i. A requester whose ack is high this cycle is ignored, which allows it to drop req on the following edge.
- Only one eligible requester: grant it.
- Both eligible: grant the requester not pointed to by the RR pointer. The pointer then records the granted requester.
- On a grant at edge t: score <= min(score+pts, MAX_SCORE); ack_i=1 during cycle t+1; dirty<=1.
- If the add clipped, saturated<=1.
- Adding 0 points still grants, acks and sets dirty.
- clr_score has priority: at that edge score<=0, saturated<=0, dirty<=1, and no grant or ack is issued. Pending requests stay pending.

FSM states:
- IDLE: if dirty, snapshot score into shift register sh, clear bcd, cnt<=0, dirty<=0, go to CONV.
- CONV: 21 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,sh} left by 1; cnt++. When cnt==20 completes, go to WAIT.
- WAIT: hold the result. On frame_start: digits<=bcd, digits_valid<=1, go to IDLE.
  - If dirty is set again while in WAIT, the result is still published at frame_start. The new value is reconverted afterwards.
  - frame_start arriving in IDLE or CONV is ignored.
- Score updates during CONV or WAIT do not disturb the snapshot.
- Latency: minimum from grant to digits update is 1 (IDLE) + 21 (CONV) + wait for frame_start. digits changes only on the edge that samples frame_start in WAIT.
- busy = (state==CONV).

Arithmetic:
- The add is performed at 22 bits, then compared against MAX_SCORE.
- BCD nibbles never exceed 9 because the score is ≤ 999999.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: at publish, each leading zero nibble (most significant first, stopping at the first nonzero digit) is replaced with 4'hF, the renderer's blank code. The units nibble is never blanked. Score 0 publishes 24'hFFFFF0.
- Undefined: digits are plain BCD with leading zeros.

Test Plan:
- Reset, then one frame_start after 23 cycles -> digits=24'h000000, digits_valid=1, score=0.
- req0 with pts0=37, then frame_start -> ack0 pulse one cycle after the grant edge; score=37; digits=24'h000037.
- req0 (pts0=5) and req1 (pts1=9) raised together from reset -> requester 1 acked first, requester 0 next cycle; score=14; digits=24'h000014.
- score preloaded to 999990 by repeated adds, then req1 with pts1=20 -> score=999999, saturated=1, digits=24'h999999. A following clr_score -> score=0, saturated=0.
- Add 100 while in CONV, frame_start arrives in WAIT -> old snapshot published first; a second conversion runs; the next frame_start publishes 24'h000100 + old value.
- clr_score and req0 in the same cycle -> no ack0 that cycle, score=0; the request is granted the next cycle. rst asserted mid-CONV -> busy=0, digits unchanged at 0.
